// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge and its peripheral map.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // PADDR bit that steers between GPIO (1) and UART (0)
    localparam int unsigned SEL_BIT = 7;

    localparam logic [7:0] GPIO_IN  = 8'h81;
    localparam logic [7:0] GPIO_OUT = 8'h82;
    localparam logic [7:0] GPIO_DIR = 8'h83;

    localparam int unsigned TIMEOUT_DEF = 16;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Saturating ACCESS-cycle counter; o_expired marks the last permitted wait cycle.
module apb_timeout_ctr #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != MAX_CNT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Count holds the number of ACCESS cycles already spent, so the current one is the LIMIT-th
    assign o_expired = i_en && (r_count >= LAST_CNT);

endmodule

// File: rtl/apb_bridge_master.sv
// Host valid/ready to APB master bridge with PADDR[7] slave decode and PREADY timeout.
module apb_bridge_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic              PREADY1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY2
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    apb_state_t r_state;
    apb_state_t w_state_next;

    logic              r_psel1;
    logic              r_psel2;
    logic              r_penable;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_accept;
    logic              w_access;
    logic              w_ready;
    logic              w_expired;
    logic [DATA_W-1:0] w_prdata;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_access = (r_state == ACCESS);
    // Only the selected slave is observed; the other slave's handshake is ignored
    assign w_ready  = r_psel1 ? PREADY1 : PREADY2;
    assign w_prdata = r_psel1 ? PRDATA1 : PRDATA2;

    apb_timeout_ctr #(
        .LIMIT (TIMEOUT),
        .CNT_W (TO_W)
    ) u_timeout_ctr (
        .i_clk     (PCLK),
        .i_rst     (PRESET),
        .i_clear   (w_accept),
        .i_en      (w_access),
        .o_expired (w_expired)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_next = SETUP;
            SETUP:   w_state_next = ACCESS;
            ACCESS:  if (w_ready || w_expired) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_psel1     <= 1'b0;
            r_psel2     <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_paddr  <= req_addr;
                        r_pwrite <= req_write;
                        r_pwdata <= req_wdata;
                        r_psel1  <= req_addr[SEL_BIT];
                        r_psel2  <= ~req_addr[SEL_BIT];
                    end
                end
                SETUP: r_penable <= 1'b1;
                ACCESS: begin
                    // PREADY wins over expiry when both land on the final allowed cycle
                    if (w_ready || w_expired) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ~w_ready;
                        r_rsp_rdata <= (w_ready && !r_pwrite) ? w_prdata : '0;
                        r_psel1     <= 1'b0;
                        r_psel2     <= 1'b0;
                        r_penable   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PSEL1     = r_psel1;
    assign PSEL2     = r_psel2;
    assign PENABLE   = r_penable;
    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_bridge_master.sv
// Scoreboard bench for apb_bridge_master: random requests and slave wait states vs. a transaction-level model.
module tb_apb_bridge_master;
    import apb_pkg::*;

    localparam int unsigned TO    = 16;
    localparam int unsigned NEVER = 1000;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL1, PSEL2, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA;
    logic [7:0] PRDATA1 = '0;
    logic [7:0] PRDATA2 = '0;
    logic       PREADY1 = 1'b0;
    logic       PREADY2 = 1'b0;

    apb_bridge_master #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .TIMEOUT (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL1     (PSEL1),
        .PSEL2     (PSEL2),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA1   (PRDATA1),
        .PREADY1   (PREADY1),
        .PRDATA2   (PRDATA2),
        .PREADY2   (PREADY2)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        err;
        logic [7:0]  rdata;
        int unsigned cyc;
        int unsigned acc;
    } exp_t;

    exp_t expq[$];

    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned acc_seen = 0;
    int unsigned last_acc = 0;
    logic        prev_sel = 1'b0;

    logic [7:0]  cur_addr = '0;
    logic [7:0]  cur_wdata = '0;
    logic [7:0]  cur_rdata = '0;
    logic        cur_wr = 1'b0;
    int unsigned cur_wait = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor and slave model: sampled/driven on the falling edge, away from the active edge.
    always @(negedge PCLK) begin
        exp_t        e;
        int unsigned k;
        PREADY1 = 1'($urandom_range(0, 1));
        PREADY2 = 1'($urandom_range(0, 1));
        PRDATA1 = 8'($urandom);
        PRDATA2 = 8'($urandom);
        if (PRESET) begin
            prev_sel = 1'b0;
        end else begin
            if (rsp_valid) begin
                chk("rsp_req_ready", 32'(req_ready), 1);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = expq.pop_front();
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("access_cycles", acc_seen, e.acc);
                end
            end
            if (PSEL1 || PSEL2) begin
                chk("psel_decode", 32'({PSEL1, PSEL2}), cur_addr[7] ? 2 : 1);
                chk("paddr", 32'(PADDR), 32'(cur_addr));
                chk("pwrite", 32'(PWRITE), 32'(cur_wr));
                chk("pwdata", 32'(PWDATA), 32'(cur_wdata));
                if (!prev_sel) begin
                    chk("setup_penable", 32'(PENABLE), 0);
                    acc_seen = 0;
                end else begin
                    chk("access_penable", 32'(PENABLE), 1);
                    k = acc_seen;
                    acc_seen++;
                    if (cur_addr[7]) begin
                        PREADY1 = (k >= cur_wait);
                        if (k >= cur_wait) PRDATA1 = cur_rdata;
                    end else begin
                        PREADY2 = (k >= cur_wait);
                        if (k >= cur_wait) PRDATA2 = cur_rdata;
                    end
                end
            end else if (PENABLE) begin
                chk("penable_without_psel", 32'(PENABLE), 0);
            end
            prev_sel = PSEL1 || PSEL2;
        end
    end

    // Issue one request (called on a falling edge); the slave answers after wt ACCESS cycles.
    task automatic do_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                          input logic [7:0] rd, input int unsigned wt, input int unsigned gap);
        int unsigned guard = 0;
        exp_t        e;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready=0 required=1 (cycle %0d)", cyc);
            req_valid = 1'b0;
            return;
        end
        cur_addr  = addr;
        cur_wr    = wr;
        cur_wdata = wd;
        cur_rdata = rd;
        cur_wait  = wt;
        last_acc  = cyc;
        e.err   = (wt >= TO);
        e.rdata = (e.err || wr) ? 8'h00 : rd;
        e.acc   = e.err ? TO : wt + 1;
        e.cyc   = cyc + 2 + e.acc;
        expq.push_back(e);
        @(negedge PCLK);
        if (gap > 0) begin
            req_valid = 1'b0;
            repeat (gap) @(negedge PCLK);
        end
    endtask

    initial begin
        int unsigned a1;
        int unsigned wt;
        #1 PRESET = 1'b1;
        #1;
        chk("reset_req_ready", 32'(req_ready), 1);
        chk("reset_psel1", 32'(PSEL1), 0);
        chk("reset_psel2", 32'(PSEL2), 0);
        chk("reset_penable", 32'(PENABLE), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_err", 32'(rsp_err), 0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 0);
        chk("reset_paddr", 32'(PADDR), 0);
        chk("reset_pwdata", 32'(PWDATA), 0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;

        do_txn(1'b1, GPIO_OUT, 8'hA5, 8'h00, 0, 2);
        do_txn(1'b0, 8'h05, 8'h00, 8'h3C, 3, 2);
        do_txn(1'b0, GPIO_IN, 8'h00, 8'h99, NEVER, 2);
        do_txn(1'b0, GPIO_DIR, 8'h00, 8'hF0, 2, 2);
        do_txn(1'b0, 8'h90, 8'h00, 8'h77, TO - 1, 1);
        do_txn(1'b0, 8'h10, 8'h00, 8'h66, TO, 1);

        do_txn(1'b1, GPIO_OUT, 8'h11, 8'h00, 0, 0);
        a1 = last_acc;
        do_txn(1'b1, 8'h03, 8'h22, 8'h00, 0, 2);
        chk("b2b_spacing", last_acc - a1, 3);

        for (int i = 0; i < 40; i++) begin
            wt = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 4);
            do_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                   wt, $urandom_range(0, 2));
        end
        req_valid = 1'b0;

        // Abort a transfer in ACCESS with an asynchronous reset
        do_txn(1'b0, GPIO_IN, 8'h00, 8'h00, NEVER, 0);
        req_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        #2 PRESET = 1'b1;
        #1;
        chk("midrst_psel1", 32'(PSEL1), 0);
        chk("midrst_psel2", 32'(PSEL2), 0);
        chk("midrst_penable", 32'(PENABLE), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_req_ready", 32'(req_ready), 1);
        expq.delete();
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (3) @(negedge PCLK);
        do_txn(1'b1, GPIO_DIR, 8'h5A, 8'h00, 1, 2);

        for (int i = 0; i < 100 && expq.size() > 0; i++) @(negedge PCLK);
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d required=0", expq.size());
        end
        repeat (2) @(negedge PCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
